wr_ptr_full_ctrl: RTL and testbench
===================================

WR_PTR_FULL_CTRL -- requirements
Module: wr_ptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, the FIFO address width; depth is 2^ADDRESS_WIDTH.
REQ-002 SHALL have parameter SYNC_STAGE, default 2, the read-pointer synchronizer depth; only 2 or 3 are legal.
REQ-003 SHALL have parameter SOFT_RESET, default 0; values 2 or 3 enable sw_rst in this write domain.
REQ-004 SHALL have parameter AFULL_THRESHOLD, default 2, the free-slot count at or below which almost_full is asserted.
REQ-005 SHALL have port clk, input, 1 bit: write-domain clock. It is the only clock.
REQ-006 SHALL have port hw_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port sw_rst, input, 1 bit: synchronous soft reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port rd_ptr_gray, input, ADDRESS_WIDTH+1 bits: Gray-coded read pointer from the read domain.
REQ-010 SHALL have port wr_ptr_gray, output, ADDRESS_WIDTH+1 bits: registered Gray-coded write pointer.
REQ-011 SHALL have port wr_addr, output, ADDRESS_WIDTH bits: RAM write address.
REQ-012 SHALL have port mem_we, output, 1 bit: qualified RAM write strobe.
REQ-013 SHALL have outputs full, almost_full and overflow, each 1 bit.
REQ-014 SHALL have output wr_level, ADDRESS_WIDTH+1 bits: write-side fill level.

Function
REQ-015 SHALL drive mem_we combinationally as wr_en AND NOT full.
REQ-016 SHALL increment binary pointer wr_bin by 1 on each clk edge where mem_we=1, wrapping modulo 2^(ADDRESS_WIDTH+1); otherwise wr_bin holds.
REQ-017 SHALL register wr_ptr_gray = next_bin XOR (next_bin >> 1) on the same edge, so exactly one bit changes per write.
REQ-018 SHALL drive wr_addr as wr_bin[ADDRESS_WIDTH-1:0].
REQ-019 SHALL pass rd_ptr_gray through SYNC_STAGE flops (latency 2 or 3 clk cycles) to give rd_sync, then convert rd_sync Gray to binary as rd_bin.
REQ-020 SHALL register full = 1 when next write Gray equals rd_sync with its two MSBs inverted and all other bits equal; full therefore asserts on the edge of the filling write.
REQ-021 SHALL register wr_level = next_bin - rd_bin, mod 2^(ADDRESS_WIDTH+1); the range is 0 to 2^ADDRESS_WIDTH.
REQ-022 SHALL register almost_full = 1 when next wr_level >= 2^ADDRESS_WIDTH - AFULL_THRESHOLD.
REQ-023 SHALL, when wr_en=1 and full=1, leave every pointer unchanged and set overflow for exactly one cycle.
REQ-024 SHALL deassert full and lower wr_level SYNC_STAGE+1 cycles after a read-pointer change, with no earlier release.
REQ-025 SHALL give reset priority over wr_en when both occur in the same cycle; the write is discarded.
REQ-026 SHALL reject SYNC_STAGE values other than 2 or 3 with an elaboration-time error.

Reset
REQ-027 SHALL, while hw_rst_n=0, asynchronously clear wr_bin, wr_ptr_gray, all synchronizer stages, full, almost_full, wr_level and overflow to 0.
REQ-028 SHALL, when sw_rst=1 and SOFT_RESET is 2 or 3, clear the same registers to 0 on the next clk edge.
REQ-029 SHALL ignore sw_rst when SOFT_RESET is 0 or 1.
REQ-030 SHALL, after either reset, resume normal operation on the first edge with reset inactive.

Configuration
REQ-031 SHALL, with macro WR_OVERFLOW_STICKY_EN defined, hold overflow at 1 from the first rejected write until hw_rst_n or an enabled sw_rst.
REQ-032 SHALL, without WR_OVERFLOW_STICKY_EN, behave as a one-cycle pulse per rejected write, as in REQ-023.

Verification (ADDRESS_WIDTH=4, SYNC_STAGE=2, AFULL_THRESHOLD=2)
REQ-033 SHALL test fill: reset, rd_ptr_gray=0, 16 writes -> wr_addr runs 0..15; after the 16th edge full=1, wr_ptr_gray=5'b11000, wr_level=16.
REQ-034 SHALL test overflow: wr_en=1 while full -> mem_we=0, wr_ptr_gray stays 5'b11000, overflow pulses one cycle; with the macro, overflow stays 1.
REQ-035 SHALL test release: from full, set rd_ptr_gray=5'b00110 (binary 4) -> full=0 and wr_level=12 exactly 3 cycles later.
REQ-036 SHALL test almost_full: 14 writes with rd_ptr_gray=0 -> almost_full=1; with a reader at level 13 -> almost_full=0.
REQ-037 SHALL test wrap: 40 writes with the reader keeping level at or below 8 -> wr_bin wraps 31 to 0, wr_ptr_gray goes 5'b10000 to 5'b00000, and full never asserts.
REQ-038 SHALL test soft reset: sw_rst=1 with wr_en=1 mid-stream -> with SOFT_RESET=3, all outputs are 0 next cycle; with SOFT_RESET=1, no effect.

Source files
------------

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer and full/level controller for an async FIFO.
// Define WR_OVERFLOW_STICKY_EN to hold overflow until reset.
module wr_ptr_full_ctrl #(
    parameter int ADDRESS_WIDTH   = 4,
    parameter int SYNC_STAGE      = 2,
    parameter int SOFT_RESET      = 0,
    parameter int AFULL_THRESHOLD = 2
) (
    input  logic                     clk,
    input  logic                     hw_rst_n,
    input  logic                     sw_rst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH:0]   rd_ptr_gray,
    output logic [ADDRESS_WIDTH:0]   wr_ptr_gray,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic                     mem_we,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [ADDRESS_WIDTH:0]   wr_level
);

    localparam int              PW          = ADDRESS_WIDTH + 1;
    localparam int              DEPTH       = 1 << ADDRESS_WIDTH;
    localparam logic [PW-1:0]   AFULL_LEVEL = PW'(DEPTH - AFULL_THRESHOLD);
    localparam bit              SOFT_EN     = (SOFT_RESET == 2) || (SOFT_RESET == 3);

    generate
        if (SYNC_STAGE != 2 && SYNC_STAGE != 3) begin : g_bad_sync_stage
            $error("wr_ptr_full_ctrl: SYNC_STAGE must be 2 or 3");
        end
    endgenerate

    logic [PW-1:0]                  wr_bin_q, wr_bin_d;
    logic [PW-1:0]                  wr_gray_q, wr_gray_d;
    logic [PW-1:0]                  level_q, level_d;
    logic                           full_q, full_d;
    logic                           afull_q, afull_d;
    logic                           ovf_q, ovf_d;
    logic [SYNC_STAGE-1:0][PW-1:0]  sync_q;
    logic [PW-1:0]                  rd_sync, rd_bin, full_pattern;
    logic                           soft_clr;

    assign soft_clr = SOFT_EN && sw_rst;
    assign rd_sync  = sync_q[SYNC_STAGE-1];
    assign mem_we   = wr_en & ~full_q;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i < PW; i++) begin
            rd_bin[i] = ^(rd_sync >> i);
        end
    end

    always_comb begin
        wr_bin_d     = wr_bin_q + PW'(mem_we);
        wr_gray_d    = wr_bin_d ^ (wr_bin_d >> 1);
        full_pattern = {~rd_sync[PW-1:PW-2], rd_sync[PW-3:0]};
        full_d       = (wr_gray_d == full_pattern);
        level_d      = wr_bin_d - rd_bin;
        afull_d      = (level_d >= AFULL_LEVEL);
`ifdef WR_OVERFLOW_STICKY_EN
        ovf_d        = ovf_q | (wr_en & full_q);
`else
        ovf_d        = wr_en & full_q;
`endif
    end

    always_ff @(posedge clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            sync_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else if (soft_clr) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            sync_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            sync_q    <= {sync_q[SYNC_STAGE-2:0], rd_ptr_gray};
            full_q    <= full_d;
            afull_q   <= afull_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_ptr_gray = wr_gray_q;
    assign wr_addr     = wr_bin_q[ADDRESS_WIDTH-1:0];
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Scoreboard bench for wr_ptr_full_ctrl: two instances (soft reset enabled / ignored)
// checked every cycle against an arithmetic occupancy model, plus directed boundary checks.
module tb_wr_ptr_full_ctrl;

    localparam int SS = 2;
`ifdef WR_OVERFLOW_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]         wr;
        logic               full;
        logic               afull;
        logic               ovf;
        logic [4:0]         level;
        logic [SS-1:0][4:0] rd_hist;
    } mst_t;

    typedef struct packed {
        logic       mem_we;
        logic [4:0] wr;
        logic       full;
        logic       afull;
        logic       ovf;
        logic [4:0] level;
    } exp_t;

    logic       clk = 1'b0;
    logic       hw_rst_n, sw_rst, wr_en;
    logic [4:0] rd_ptr_gray;
    logic [4:0] gray_a, gray_b, level_a, level_b;
    logic [3:0] addr_a, addr_b;
    logic       we_a, we_b, full_a, full_b, af_a, af_b, ovf_a, ovf_b;

    int   n_chk  = 0;
    int   n_fail = 0;
    mst_t ma = '0;
    mst_t mb = '0;
    exp_t qa[$];
    exp_t qb[$];
    logic [4:0] rd_b;

    always #5 clk = ~clk;

    wr_ptr_full_ctrl #(.ADDRESS_WIDTH(4), .SYNC_STAGE(2), .SOFT_RESET(3), .AFULL_THRESHOLD(2)) dut_a (
        .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
        .wr_ptr_gray(gray_a), .wr_addr(addr_a), .mem_we(we_a), .full(full_a),
        .almost_full(af_a), .overflow(ovf_a), .wr_level(level_a));

    wr_ptr_full_ctrl #(.ADDRESS_WIDTH(4), .SYNC_STAGE(2), .SOFT_RESET(1), .AFULL_THRESHOLD(2)) dut_b (
        .clk(clk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
        .wr_ptr_gray(gray_b), .wr_addr(addr_b), .mem_we(we_b), .full(full_b),
        .almost_full(af_b), .overflow(ovf_b), .wr_level(level_b));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy model: writes counted mod 32, level = writes - reader seen SS+1 edges late.
    function automatic void step(inout mst_t s, output exp_t e, input bit rn, input bit sw,
                                 input bit we, input logic [4:0] rd, input bit soft_en);
        logic [4:0] seen;
        if (!rn) s = '0;
        e.mem_we = we && !s.full;
        if (!rn || (sw && soft_en)) begin
            s = '0;
        end else begin
            seen      = s.rd_hist[SS-1];
            s.rd_hist = {s.rd_hist[SS-2:0], rd};
            s.ovf     = STICKY ? (s.ovf | (we & s.full)) : (we & s.full);
            if (e.mem_we) s.wr = s.wr + 5'd1;
            s.level   = s.wr - seen;
            s.full    = (s.level == 5'd16);
            s.afull   = (s.level >= 5'd14);
        end
        e.wr = s.wr; e.full = s.full; e.afull = s.afull; e.ovf = s.ovf; e.level = s.level;
    endfunction

    task automatic tick(input bit rn, input bit sw, input bit we, input logic [4:0] rd);
        exp_t ea, eb;
        @(negedge clk);
        hw_rst_n    = rn;
        sw_rst      = sw;
        wr_en       = we;
        rd_ptr_gray = rd ^ (rd >> 1);
        step(ma, ea, rn, sw, we, rd, 1'b1);
        step(mb, eb, rn, sw, we, rd, 1'b0);
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #2;
    endtask

    task automatic check_regs(input string tag, input exp_t e, input logic [4:0] gray,
                              input logic [3:0] addr, input logic fl, input logic af,
                              input logic ov, input logic [4:0] lvl);
        logic [4:0] eg;
        eg = e.wr ^ (e.wr >> 1);
        chk({tag, "_gray"},  int'(gray), int'(eg));
        chk({tag, "_addr"},  int'(addr), int'(e.wr[3:0]));
        chk({tag, "_full"},  int'(fl),   int'(e.full));
        chk({tag, "_afull"}, int'(af),   int'(e.afull));
        chk({tag, "_ovf"},   int'(ov),   int'(e.ovf));
        chk({tag, "_level"}, int'(lvl),  int'(e.level));
    endtask

    initial begin : monitor
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            #3;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_mem_we", int'(we_a), int'(ea.mem_we));
                chk("b_mem_we", int'(we_b), int'(eb.mem_we));
                @(posedge clk);
                #1;
                check_regs("a", ea, gray_a, addr_a, full_a, af_a, ovf_a, level_a);
                check_regs("b", eb, gray_b, addr_b, full_b, af_b, ovf_b, level_b);
            end
        end
    end

    initial begin : stim
        logic [4:0] rd;
        bit rn, sw, we;
        hw_rst_n = 1'b0; sw_rst = 1'b0; wr_en = 1'b0; rd_ptr_gray = '0; rd_b = '0;

        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        chk("rst_gray",  int'(gray_a),  0);
        chk("rst_full",  int'(full_a),  0);
        chk("rst_level", int'(level_a), 0);
        chk("rst_ovf",   int'(ovf_a),   0);

        for (int i = 0; i < 16; i++) begin
            chk("fill_addr", int'(addr_a), i);
            tick(1, 0, 1, 0);
        end
        chk("fill_full",  int'(full_a),  1);
        chk("fill_gray",  int'(gray_a),  int'(5'b11000));
        chk("fill_level", int'(level_a), 16);

        tick(1, 0, 1, 0);
        chk("ovf_set",  int'(ovf_a),  1);
        chk("ovf_gray", int'(gray_a), int'(5'b11000));
        tick(1, 0, 0, 0);
        chk("ovf_after", int'(ovf_a), STICKY ? 1 : 0);

        tick(1, 0, 0, 5'd4);
        chk("rel_full_1", int'(full_a), 1);
        tick(1, 0, 0, 5'd4);
        chk("rel_full_2", int'(full_a), 1);
        tick(1, 0, 0, 5'd4);
        chk("rel_full_3",  int'(full_a),  0);
        chk("rel_level_3", int'(level_a), 12);

        tick(0, 0, 0, 0);
        for (int i = 0; i < 13; i++) tick(1, 0, 1, 0);
        chk("af_13", int'(af_a), 0);
        tick(1, 0, 1, 0);
        chk("af_14", int'(af_a), 1);
        tick(1, 0, 0, 5'd1);
        tick(1, 0, 0, 5'd1);
        chk("af_hold", int'(af_a), 1);
        tick(1, 0, 0, 5'd1);
        chk("af_rel",       int'(af_a),    0);
        chk("af_rel_level", int'(level_a), 13);

        tick(0, 0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            rd = (k >= 5) ? 5'(k - 5) : 5'd0;
            tick(1, 0, 1, rd);
            chk("wrap_nofull", int'(full_a), 0);
            chk("wrap_le8", int'(level_a <= 5'd8), 1);
            if (k == 31) chk("wrap_gray31", int'(gray_a), int'(5'b10000));
            if (k == 32) chk("wrap_gray32", int'(gray_a), 0);
        end

        tick(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 1, 0);
        tick(1, 1, 1, 0);
        chk("sr3_addr",  int'(addr_a),  0);
        chk("sr3_gray",  int'(gray_a),  0);
        chk("sr3_level", int'(level_a), 0);
        chk("sr1_addr",  int'(addr_b),  6);
        chk("sr1_level", int'(level_b), 6);
        tick(1, 0, 1, 0);
        chk("sr3_resume", int'(addr_a), 1);
        chk("sr1_resume", int'(addr_b), 7);

        tick(0, 0, 0, 0);
        rd_b = '0;
        for (int n = 0; n < 800; n++) begin
            rn = ($urandom_range(0, 149) != 0);
            sw = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 3) != 0);
            if (!rn || sw) rd_b = '0;
            else if ($urandom_range(0, 1) == 1 && ma.wr != rd_b) rd_b = rd_b + 5'd1;
            tick(rn, sw, we, rd_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
